pop_acc_sign: RTL and testbench
===============================

// Module: pop_acc_sign
// PURPOSE
//   Stage downstream of the XNOR-popcount block. Accumulates CHUNKS partial popcounts per neuron
//   and thresholds the sum into one binary activation (folded batch-norm + sign). Packs OUT_BITS
//   activations LSB-first into a word for the next binarized layer. Valid/ready on both sides.
// PARAMETERS
//   POP_W    10   width of in_pop (clog2 of padded popcount size, e.g. 576 -> 10)
//   CHUNKS   4    partial popcounts per neuron (>=1)
//   N_TOTAL  2304 total XNOR terms per neuron; used only with POPACC_BIPOLAR_EN
//   OUT_BITS 32   activations per output word (>=2)
//   ACC_W    clog2(CHUNKS*(2**POP_W-1)+1)+1   accumulator/threshold width, two's complement
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        in_pop/in_thr/in_flip valid
//   in_ready   out  1        stage can accept a chunk
//   in_pop     in   POP_W    partial popcount, unsigned
//   in_thr     in   ACC_W    neuron threshold, signed; sampled with chunk 0 only
//   in_flip    in   1        invert activation (negative BN gamma); sampled with chunk 0 only
//   flush      in   1        request emission of a partial word
//   out_valid  out  1        out_word valid
//   out_ready  in   1        consumer accepts out_word
//   out_word   out  OUT_BITS packed activations, bit i = i-th neuron of the word
//   out_nbits  out  clog2(OUT_BITS+1)  count of valid bits in out_word (OUT_BITS if full)
// BEHAVIOUR
//   Reset: out_valid=0, out_word=0, out_nbits=0, in_ready=1; acc, chunk_cnt, bit_cnt, flush_pend cleared.
//   in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
//   Accumulate: chunk_cnt==0 -> acc<=zext(in_pop), thr/flip latched; else acc<=acc+in_pop.
//   chunk_cnt wraps CHUNKS-1 -> 0. No overflow possible by ACC_W sizing.
//   On the final chunk: sum = acc+in_pop (combinational); act = (sum >= thr) ^ flip.
//   act shifts into pack_reg[bit_cnt]; bit_cnt++.
//   Word full (bit_cnt reaches OUT_BITS): pack_reg copied to out_word next cycle.
//   That edge sets out_valid=1, out_nbits=OUT_BITS, bit_cnt=0, pack_reg=0.
//   Latency: final-chunk in_fire -> out_valid high exactly 1 cycle later.
//   Output register is a 1-deep skid: accumulation of the next word continues while out_valid=1.
//   in_ready=0 only while out_valid=1, !out_ready, and the pending chunk would complete a word
//   (final chunk with bit_cnt==OUT_BITS-1) or a flush. Same-cycle out_fire frees the slot (in_ready=1).
//   out_word/out_nbits stable while out_valid & !out_ready. out_valid drops after out_fire
//   unless a new word loads that same edge.
//   Flush: sets sticky flush_pend. Acted on when chunk_cnt==0 and no in_fire that cycle.
//   bit_cnt>0 -> emit pack_reg with out_nbits=bit_cnt, zero MSBs. bit_cnt==0 -> flush_pend cleared silently.
//   flush during a neuron waits until that neuron completes; its bit is included.
//   Reset mid-operation: partial acc and pack_reg discarded, no word emitted.
// CONFIGURATION
//   POPACC_BIPOLAR_EN defined: compare value = 2*sum - N_TOTAL (bipolar +/-1 dot product, signed).
//   in_thr is then in the same bipolar domain.
//   POPACC_BIPOLAR_EN undefined: compare value = sum as non-negative signed ACC_W.
//   Ports and parameters are identical in both builds.
// STRUCTURE
//   Package pop_acc_pkg: ACC_W/count-width functions, acc_t and thr_t typedefs.
//   Package also holds state enum {S_ACC, S_FLUSH} (S_FLUSH: one cycle emitting a partial word).
//   Sub-module bit_packer: shift-in/count/flush and output skid register.
//   pop_acc_sign keeps the accumulator, threshold compare and in_ready logic.
// TESTING (defaults POP_W=10 CHUNKS=4 OUT_BITS=32 unless noted)
//   1 Chunks 100,200,300,400, thr=1000, flip=0 -> act=1. Same chunks, thr=1001 -> act=0.
//     flip=1 inverts both.
//   2 32 neurons, act pattern 0xA5A5_5A5A, out_ready=1 -> out_valid 1 cycle after the 128th in_fire.
//     Expect out_word=0xA5A5_5A5A, out_nbits=32.
//   3 out_ready=0 with a full word held -> 31 more neurons accepted.
//     in_ready=0 on the final chunk of the 32nd; out_ready=1 -> same cycle in_ready=1, no data loss.
//   4 5 neurons all act=1, then flush -> out_word=0x0000_001F, out_nbits=5.
//     flush with bit_cnt=0 -> no out_valid.
//   5 flush asserted at chunk 2 of neuron 3 -> neuron 3 completes, word emitted with out_nbits=3.
//   6 rst_n low mid-word -> all outputs 0 async. With POPACC_BIPOLAR_EN, N_TOTAL=2304:
//     sum=1152 thr=0 -> act=1; sum=1151 -> act=0.

Source files
------------

// File: rtl/pop_acc_pkg.sv
// Shared widths, typedefs and packer state for the popcount accumulate/sign stage.
package pop_acc_pkg;

  function automatic int calc_acc_w(input int pop_w, input int chunks);
    return $clog2(chunks * ((1 << pop_w) - 1) + 1) + 1;
  endfunction

  function automatic int calc_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int POP_W_DEF  = 10;
  localparam int CHUNKS_DEF = 4;
  localparam int ACC_W_DEF  = calc_acc_w(POP_W_DEF, CHUNKS_DEF);

  typedef logic signed [ACC_W_DEF-1:0] acc_t;
  typedef logic signed [ACC_W_DEF-1:0] thr_t;

  // S_FLUSH marks the cycle in which a partial word is moved to the output
  typedef enum logic {S_ACC, S_FLUSH} pack_state_e;

endpackage

// File: rtl/pop_acc_sign_bit_packer.sv
// Packs activations LSB-first, handles sticky flush, and owns the 1-deep output skid register.
module bit_packer
  import pop_acc_pkg::*;
#(
  parameter  int OUT_BITS = 32,
  localparam int NB_W     = $clog2(OUT_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                act_valid,
  input  logic                act,
  input  logic                flush,
  input  logic                idle,
  input  logic                out_ready,
  output logic                last_slot,
  output logic                flush_wait,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_word,
  output logic [NB_W-1:0]     out_nbits
);

  logic [OUT_BITS-1:0] pack_reg;
  logic [OUT_BITS-1:0] hit_mask;
  logic [OUT_BITS-1:0] pack_set;
  logic [NB_W-1:0]     bit_cnt_reg;
  logic                flush_pend_reg;
  logic                slot_free;
  logic                flush_clear;
  logic                full_load;
  pack_state_e         state;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_BITS; gi++) begin : g_hit
      assign hit_mask[gi] = (bit_cnt_reg == NB_W'(gi));
    end
  endgenerate

  assign pack_set    = pack_reg | ((act_valid & act) ? hit_mask : '0);
  assign last_slot   = (bit_cnt_reg == NB_W'(OUT_BITS - 1));
  assign flush_wait  = flush_pend_reg & (bit_cnt_reg != '0);
  assign slot_free   = !out_valid | out_ready;
  assign full_load   = act_valid & last_slot;
  // An empty word clears the flush without needing the output slot
  assign flush_clear = flush_pend_reg & idle & ((bit_cnt_reg == '0) | slot_free);

  always_comb begin
    state = S_ACC;
    if (flush_pend_reg && idle && (bit_cnt_reg != '0) && slot_free)
      state = S_FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_reg       <= '0;
      bit_cnt_reg    <= '0;
      flush_pend_reg <= 1'b0;
      out_valid      <= 1'b0;
      out_word       <= '0;
      out_nbits      <= '0;
    end else begin
      flush_pend_reg <= (flush_pend_reg & !flush_clear) | flush;
      if (full_load) begin
        out_word    <= pack_set;
        out_nbits   <= NB_W'(OUT_BITS);
        out_valid   <= 1'b1;
        pack_reg    <= '0;
        bit_cnt_reg <= '0;
      end else if (state == S_FLUSH) begin
        out_word    <= pack_reg;
        out_nbits   <= bit_cnt_reg;
        out_valid   <= 1'b1;
        pack_reg    <= '0;
        bit_cnt_reg <= '0;
      end else begin
        if (out_ready)
          out_valid <= 1'b0;
        if (act_valid) begin
          pack_reg    <= pack_set;
          bit_cnt_reg <= bit_cnt_reg + NB_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pop_acc_sign.sv
// Accumulates CHUNKS partial popcounts per neuron and thresholds them into packed activations.
// Define POPACC_BIPOLAR_EN to compare 2*sum-N_TOTAL instead of the raw sum.
module pop_acc_sign
  import pop_acc_pkg::*;
#(
  parameter  int POP_W    = 10,
  parameter  int CHUNKS   = 4,
  parameter  int N_TOTAL  = 2304,
  parameter  int OUT_BITS = 32,
  localparam int ACC_W    = calc_acc_w(POP_W, CHUNKS),
  localparam int NB_W     = $clog2(OUT_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [POP_W-1:0]    in_pop,
  input  logic [ACC_W-1:0]    in_thr,
  input  logic                in_flip,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_word,
  output logic [NB_W-1:0]     out_nbits
);

  localparam int CW    = calc_cnt_w(CHUNKS);
  localparam int CMP_W = ACC_W + 2;

  logic [CW-1:0]           chunk_cnt_reg;
  logic [ACC_W-1:0]        acc_reg;
  logic [ACC_W-1:0]        thr_reg;
  logic                    flip_reg;
  logic                    first_chunk;
  logic                    last_chunk;
  logic                    in_fire;
  logic [ACC_W-1:0]        sum;
  logic [ACC_W-1:0]        thr_sel;
  logic                    flip_sel;
  logic signed [CMP_W-1:0] cmp_val;
  logic signed [CMP_W-1:0] thr_ext;
  logic                    act;
  logic                    last_slot;
  logic                    flush_wait;

  assign first_chunk = (chunk_cnt_reg == '0);
  assign last_chunk  = (chunk_cnt_reg == CW'(CHUNKS - 1));
  assign in_fire     = in_valid & in_ready;

  // Chunk 0 bypasses the latched threshold/flip so CHUNKS==1 works unchanged
  assign sum      = (first_chunk ? '0 : acc_reg) + ACC_W'(in_pop);
  assign thr_sel  = first_chunk ? in_thr  : thr_reg;
  assign flip_sel = first_chunk ? in_flip : flip_reg;
  assign thr_ext  = {{2{thr_sel[ACC_W-1]}}, thr_sel};

`ifdef POPACC_BIPOLAR_EN
  assign cmp_val = $signed({1'b0, sum, 1'b0}) - $signed(CMP_W'(N_TOTAL));
`else
  assign cmp_val = $signed({2'b00, sum});
`endif

  assign act = (cmp_val >= thr_ext) ^ flip_sel;

  // Stall only when the chunk would need the occupied output slot
  assign in_ready = !(out_valid && !out_ready &&
                      ((last_chunk && last_slot) || (first_chunk && flush_wait)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk_cnt_reg <= '0;
      acc_reg       <= '0;
      thr_reg       <= '0;
      flip_reg      <= 1'b0;
    end else if (in_fire) begin
      acc_reg       <= sum;
      chunk_cnt_reg <= last_chunk ? '0 : chunk_cnt_reg + CW'(1);
      if (first_chunk) begin
        thr_reg  <= in_thr;
        flip_reg <= in_flip;
      end
    end
  end

  bit_packer #(
    .OUT_BITS(OUT_BITS)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .act_valid  (in_fire & last_chunk),
    .act        (act),
    .flush      (flush),
    .idle       (first_chunk & !in_fire),
    .out_ready  (out_ready),
    .last_slot  (last_slot),
    .flush_wait (flush_wait),
    .out_valid  (out_valid),
    .out_word   (out_word),
    .out_nbits  (out_nbits)
  );

endmodule

// File: tb/tb_pop_acc_sign.sv
// Directed bench for pop_acc_sign: thresholding, packing, skid back-pressure, flush and reset.
module tb_pop_acc_sign;

  localparam int POP_W    = 10;
  localparam int ACC_W    = 13;
  localparam int OUT_BITS = 32;
  localparam int NB_W     = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [POP_W-1:0]    in_pop;
  logic [ACC_W-1:0]    in_thr;
  logic                in_flip;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_word;
  logic [NB_W-1:0]     out_nbits;

  int vectors     = 0;
  int miscompares = 0;

  pop_acc_sign dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pop    (in_pop),
    .in_thr    (in_thr),
    .in_flip   (in_flip),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_nbits (out_nbits)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Threshold that makes a chunk sum compare true (want=1) or false (want=0)
  function automatic logic [ACC_W-1:0] thr_for(input int s, input bit want);
`ifdef POPACC_BIPOLAR_EN
    return ACC_W'(2 * s - 2304 + (want ? 0 : 1));
`else
    return ACC_W'(s + (want ? 0 : 1));
`endif
  endfunction

  task automatic send_chunk(input logic [POP_W-1:0] pop, input logic [ACC_W-1:0] thr, input bit flp);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_pop   = pop;
    in_thr   = thr;
    in_flip  = flp;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout observed in_ready=0 expected in_ready=1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  // Sum 1000 over four chunks; threshold chosen so the activation equals a
  task automatic send_neuron(input bit a, input bit flp);
    logic [ACC_W-1:0] t;
    t = thr_for(1000, a ^ flp);
    send_chunk(10'd100, t, flp);
    send_chunk(10'd200, t, flp);
    send_chunk(10'd300, t, flp);
    send_chunk(10'd400, t, flp);
  endtask

  task automatic wait_out(output bit got);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    got = out_valid;
  endtask

  task automatic do_flush();
    in_valid = 1'b0;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  bit got;
  bit seen;
  logic [31:0] pat;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pop    = '0;
    in_thr    = '0;
    in_flip   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_word",  out_word,       32'd0);
    chk("reset_out_nbits", 32'(out_nbits), 32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Threshold edge 1000/1001 with and without flip -> bits 1,0,0,1
    send_neuron(1'b1, 1'b0);
    send_neuron(1'b0, 1'b0);
    send_neuron(1'b0, 1'b1);
    send_neuron(1'b1, 1'b1);
    do_flush();
    wait_out(got);
    chk("t1_valid", 32'(got),       32'd1);
    chk("t1_word",  out_word,       32'h0000_0009);
    chk("t1_nbits", 32'(out_nbits), 32'd4);
    @(posedge clk);
    #1;
    chk("t1_drop", 32'(out_valid), 32'd0);

    // Full word, back-to-back chunks, exact one-cycle latency
    pat = 32'hA5A5_5A5A;
    for (int i = 0; i < 31; i++) send_neuron(pat[i], 1'b0);
    chk("t2_not_early", 32'(out_valid), 32'd0);
    send_neuron(pat[31], 1'b0);
    in_valid = 1'b0;
    chk("t2_latency", 32'(out_valid), 32'd1);
    chk("t2_word",    out_word,       32'hA5A5_5A5A);
    chk("t2_nbits",   32'(out_nbits), 32'd32);
    @(posedge clk);
    #1;
    chk("t2_drop", 32'(out_valid), 32'd0);

    // Skid: hold one word, accumulate the next, stall on its last bit
    out_ready = 1'b0;
    pat = 32'h1234_5678;
    for (int i = 0; i < 32; i++) send_neuron(pat[i], 1'b0);
    in_valid = 1'b0;
    chk("t3_held_valid", 32'(out_valid), 32'd1);
    chk("t3_held_word",  out_word,       32'h1234_5678);
    pat = 32'hDEAD_BEEF;
    for (int i = 0; i < 31; i++) send_neuron(pat[i], 1'b0);
    send_chunk(10'd100, thr_for(1000, pat[31]), 1'b0);
    send_chunk(10'd200, thr_for(1000, pat[31]), 1'b0);
    send_chunk(10'd300, thr_for(1000, pat[31]), 1'b0);
    in_valid = 1'b1;
    in_pop   = 10'd400;
    @(negedge clk);
    chk("t3_stall", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_stall_hold", 32'(in_ready), 32'd0);
    chk("t3_word_stable", out_word, 32'h1234_5678);
    out_ready = 1'b1;
    #1;
    chk("t3_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t3_next_valid", 32'(out_valid), 32'd1);
    chk("t3_next_word",  out_word,       32'hDEAD_BEEF);
    chk("t3_next_nbits", 32'(out_nbits), 32'd32);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_drop", 32'(out_valid), 32'd0);

    // Partial word flush, then a flush with nothing buffered
    for (int i = 0; i < 5; i++) send_neuron(1'b1, 1'b0);
    do_flush();
    wait_out(got);
    chk("t4_valid", 32'(got),       32'd1);
    chk("t4_word",  out_word,       32'h0000_001F);
    chk("t4_nbits", 32'(out_nbits), 32'd5);
    @(posedge clk);
    #1;
    do_flush();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= out_valid;
      @(posedge clk);
      #1;
    end
    chk("t4_empty_flush", 32'(seen), 32'd0);

    // Flush raised mid-neuron waits for that neuron
    send_neuron(1'b1, 1'b0);
    send_neuron(1'b0, 1'b0);
    send_chunk(10'd100, thr_for(1000, 1'b1), 1'b0);
    send_chunk(10'd200, thr_for(1000, 1'b1), 1'b0);
    flush = 1'b1;
    send_chunk(10'd300, thr_for(1000, 1'b1), 1'b0);
    flush = 1'b0;
    chk("t5_no_early", 32'(out_valid), 32'd0);
    send_chunk(10'd400, thr_for(1000, 1'b1), 1'b0);
    in_valid = 1'b0;
    wait_out(got);
    chk("t5_valid", 32'(got),       32'd1);
    chk("t5_word",  out_word,       32'h0000_0005);
    chk("t5_nbits", 32'(out_nbits), 32'd3);
    @(posedge clk);
    #1;

    // Asynchronous reset with a held word and a partial word in flight
    out_ready = 1'b0;
    pat = 32'hCAFE_F00D;
    for (int i = 0; i < 32; i++) send_neuron(pat[i], 1'b0);
    for (int i = 0; i < 3; i++) send_neuron(1'b1, 1'b0);
    send_chunk(10'd100, thr_for(1000, 1'b1), 1'b0);
    in_valid = 1'b0;
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_word",  out_word,       32'd0);
    chk("t6_rst_nbits", 32'(out_nbits), 32'd0);
    chk("t6_rst_ready", 32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
`ifdef POPACC_BIPOLAR_EN
    in_thr = ACC_W'(0);
`else
    in_thr = ACC_W'(1152);
`endif
    send_chunk(10'd288, in_thr, 1'b0);
    send_chunk(10'd288, in_thr, 1'b0);
    send_chunk(10'd288, in_thr, 1'b0);
    send_chunk(10'd288, in_thr, 1'b0);
    send_chunk(10'd288, in_thr, 1'b0);
    send_chunk(10'd288, in_thr, 1'b0);
    send_chunk(10'd288, in_thr, 1'b0);
    send_chunk(10'd287, in_thr, 1'b0);
    do_flush();
    wait_out(got);
    chk("t6_after_valid", 32'(got),       32'd1);
    chk("t6_after_word",  out_word,       32'h0000_0001);
    chk("t6_after_nbits", 32'(out_nbits), 32'd2);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
